// File: rtl/goldschmidt_div_seq_if.sv
// Request/result bundle for the sequential Goldschmidt divider.
interface goldschmidt_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic             rem_zero;
    logic             div_by_zero;
    logic             range_err;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, rem_zero, div_by_zero, range_err
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, rem_zero, div_by_zero, range_err
    );
endinterface

// File: rtl/goldschmidt_div_seq.sv
// Iterative Goldschmidt divider for normalised Q1.(WIDTH-1) operands.
// One (WIDTH+GUARD)-square multiplier is time-shared between the n/d
// iterations and the final q*D product; a one-step remainder correction
// turns the converged estimate into the exact truncated quotient.

// Watches the correction window: the iteration must land within one ulp.
module goldschmidt_div_seq_chk (
    input logic clk,
    input logic reset,
    input logic check_s,
    input logic big_err_s
);
    a_corr_window: assert property (@(posedge clk) disable iff (!reset) (check_s |-> !big_err_s));
endmodule

module goldschmidt_div_seq #(
    parameter int WIDTH = 32,
    parameter int ITERS = 6,
    parameter int GUARD = 4
) (
    input logic                  clk,
    input logic                  reset,
    goldschmidt_div_seq_if.slave bus
);
    localparam int W2 = WIDTH + GUARD;
    localparam int RW = 2 * WIDTH + 2;
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    // 0.75 in Q1.(W2-1): bits for 0.5 and 0.25 set
    localparam logic [W2-1:0] K0 = {3'b011, {(W2-3){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULN = 3'd1,
        S_MULD = 3'd2,
        S_CORR = 3'd3,
        S_FIX  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   n_in_r, d_in_r;
    logic [W2-1:0]      n_r, d_r, k_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] p_r;
    logic               err_dz_r, err_re_r;

    logic               busy_r, done_r, rem_zero_r, div_by_zero_r, range_err_r;
    logic [WIDTH-1:0]   quotient_r;

    logic               accept_s, last_s, in_dz_s, in_re_s;
    logic [WIDTH-1:0]   q_s, q_fix_s;
    logic [W2-1:0]      mul_a_s, mul_b_s, prod_q_s;
    logic [2*W2-1:0]    prod_s;
    logic signed [RW-1:0] r_s, d_ext_s, d2_s, r_adj_s;
    logic               rz_s, big_err_s, fix_norm_s, unused_s;

    // A request is taken only in IDLE and never in the cycle showing done.
    assign accept_s = (state_r == S_IDLE) && bus.start && !done_r;
    assign in_dz_s  = (bus.divisor == {WIDTH{1'b0}});
    assign in_re_s  = ((bus.dividend != {WIDTH{1'b0}}) && !bus.dividend[WIDTH-1])
                      || !bus.divisor[WIDTH-1];
    assign last_s   = (cnt_r == CW'(ITERS - 1));
    assign q_s      = n_r[W2-1:GUARD];

    // Shared multiplier operand select; CORR reuses it for q*D.
    always_comb begin
        mul_a_s = {W2{1'b0}};
        mul_b_s = {W2{1'b0}};
        case (state_r)
            S_MULN: begin
                mul_a_s = n_r;
                mul_b_s = k_r;
            end
            S_MULD: begin
                mul_a_s = d_r;
                mul_b_s = k_r;
            end
            S_CORR: begin
                mul_a_s = {{GUARD{1'b0}}, q_s};
                mul_b_s = {{GUARD{1'b0}}, d_in_r};
            end
            default: begin
                mul_a_s = {W2{1'b0}};
                mul_b_s = {W2{1'b0}};
            end
        endcase
    end

    assign prod_s   = {{W2{1'b0}}, mul_a_s} * {{W2{1'b0}}, mul_b_s};
    // Q1.x * Q1.x -> Q2.2x; keep the Q1.x window, top bit is always zero here
    assign prod_q_s = prod_s[2*W2-2 -: W2];
    assign unused_s = prod_s[2*W2-1];

    // Remainder-based correction of the truncated estimate.
    always_comb begin
        r_s        = $signed({3'b000, n_in_r, {(WIDTH-1){1'b0}}}) - $signed({2'b00, p_r});
        d_ext_s    = $signed({{(WIDTH+2){1'b0}}, d_in_r});
        d2_s       = $signed({d_ext_s[RW-2:0], 1'b0});
        q_fix_s    = q_s;
        r_adj_s    = r_s;
        if (r_s[RW-1]) begin
            q_fix_s = q_s - WIDTH'(1);
            r_adj_s = r_s + d_ext_s;
        end else if (r_s >= d_ext_s) begin
            q_fix_s = q_s + WIDTH'(1);
            r_adj_s = r_s - d_ext_s;
        end else begin
            q_fix_s = q_s;
            r_adj_s = r_s;
        end
        rz_s       = (r_adj_s == {RW{1'b0}});
        big_err_s  = (r_s > d2_s) || (r_s < -d2_s);
        fix_norm_s = (state_r == S_FIX) && !err_dz_r && !err_re_r;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: MULN/MULD pairs ITERS times, then CORR and FIX.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = (in_dz_s || in_re_s) ? S_FIX : S_MULN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MULN:  state_s = S_MULD;
            S_MULD:  state_s = last_s ? S_CORR : S_MULN;
            S_CORR:  state_s = S_FIX;
            S_FIX:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_in_r   <= {WIDTH{1'b0}};
            d_in_r   <= {WIDTH{1'b0}};
            n_r      <= {W2{1'b0}};
            d_r      <= {W2{1'b0}};
            k_r      <= {W2{1'b0}};
            cnt_r    <= {CW{1'b0}};
            p_r      <= {(2*WIDTH){1'b0}};
            err_dz_r <= 1'b0;
            err_re_r <= 1'b0;
        end else if (accept_s) begin
            n_in_r   <= bus.dividend;
            d_in_r   <= bus.divisor;
            n_r      <= {bus.dividend, {GUARD{1'b0}}};
            d_r      <= {bus.divisor, {GUARD{1'b0}}};
            k_r      <= K0;
            cnt_r    <= {CW{1'b0}};
            err_dz_r <= in_dz_s;
            err_re_r <= !in_dz_s && in_re_s;
        end else begin
            case (state_r)
                S_MULN: n_r <= prod_q_s;
                S_MULD: begin
                    d_r   <= prod_q_s;
                    k_r   <= (~prod_q_s) + W2'(1);
                    cnt_r <= cnt_r + CW'(1);
                end
                S_CORR:  p_r <= prod_s[2*WIDTH-1:0];
                default: n_r <= n_r;
            endcase
        end
    end

    // Registered handshake and result outputs; flags clear on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            quotient_r    <= {WIDTH{1'b0}};
            rem_zero_r    <= 1'b0;
            div_by_zero_r <= 1'b0;
            range_err_r   <= 1'b0;
        end else if (accept_s) begin
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
            rem_zero_r    <= 1'b0;
            div_by_zero_r <= 1'b0;
            range_err_r   <= 1'b0;
        end else if (state_r == S_FIX) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            if (err_dz_r) begin
                quotient_r    <= {WIDTH{1'b1}};
                div_by_zero_r <= 1'b1;
            end else if (err_re_r) begin
                quotient_r  <= {WIDTH{1'b0}};
                range_err_r <= 1'b1;
            end else begin
                quotient_r <= q_fix_s;
                rem_zero_r <= rz_s;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.rem_zero    = rem_zero_r;
    assign bus.div_by_zero = div_by_zero_r;
    assign bus.range_err   = range_err_r;

    goldschmidt_div_seq_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .check_s   (fix_norm_s),
        .big_err_s (big_err_s)
    );
endmodule

// File: tb/tb_goldschmidt_div_seq.sv
// Bench for goldschmidt_div_seq: a 32-bit/6-iteration unit and a
// 16-bit/5-iteration unit, checked every cycle against a transaction-level
// model built on plain integer division.
module tb_goldschmidt_div_seq;
    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    goldschmidt_div_seq_if #(.WIDTH(32)) b0 ();
    goldschmidt_div_seq_if #(.WIDTH(16)) b1 ();

    goldschmidt_div_seq #(.WIDTH(32), .ITERS(6), .GUARD(4)) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );
    goldschmidt_div_seq #(.WIDTH(16), .ITERS(5), .GUARD(4)) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // expected outputs per unit
    logic [31:0] q_e[2], pq[2];
    logic        busy_e[2], done_e[2], rz_e[2], dz_e[2], re_e[2];
    logic        prz[2], pdz[2], pre[2], pend[2];
    longint      done_at[2], free_at[2];
    longint      cyc;

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s unit%0d: got %h expected %h", nm, u, act, exp);
        end
    endtask

    function automatic void golden(input int w, input logic [31:0] n, input logic [31:0] d,
                                   output logic [31:0] q, output logic rz,
                                   output logic dz, output logic re);
        logic [31:0] m, msb;
        logic [63:0] num;
        m   = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        msb = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
        q = 32'd0; rz = 1'b0; dz = 1'b0; re = 1'b0;
        if (d == 32'd0) begin
            dz = 1'b1;
            q  = m;
        end else if (((n != 32'd0) && ((n & msb) == 32'd0)) || ((d & msb) == 32'd0)) begin
            re = 1'b1;
        end else begin
            num = {32'd0, n} << (w - 1);
            q   = 32'(num / {32'd0, d});
            rz  = ((num % {32'd0, d}) == 64'd0);
        end
    endfunction

    // Transaction model: accept, fixed latency, result appears with done.
    initial begin
        logic        m_st, g_rz, g_dz, g_re;
        logic [31:0] m_n, m_d, g_q;
        int          lat;
        cyc = 0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                for (int u = 0; u < 2; u++) begin
                    busy_e[u] = 1'b0; done_e[u] = 1'b0; q_e[u] = 32'd0;
                    rz_e[u] = 1'b0; dz_e[u] = 1'b0; re_e[u] = 1'b0;
                    pend[u] = 1'b0; free_at[u] = 0;
                end
            end else begin
                cyc++;
                for (int u = 0; u < 2; u++) begin
                    done_e[u] = 1'b0;
                    if (pend[u] && cyc == done_at[u]) begin
                        done_e[u] = 1'b1; busy_e[u] = 1'b0; pend[u] = 1'b0;
                        q_e[u] = pq[u]; rz_e[u] = prz[u]; dz_e[u] = pdz[u]; re_e[u] = pre[u];
                    end
                    if (u == 0) begin
                        m_st = b0.start; m_n = b0.dividend; m_d = b0.divisor;
                    end else begin
                        m_st = b1.start; m_n = {16'd0, b1.dividend}; m_d = {16'd0, b1.divisor};
                    end
                    if (!pend[u] && cyc >= free_at[u] && m_st) begin
                        golden((u == 0) ? 32 : 16, m_n, m_d, g_q, g_rz, g_dz, g_re);
                        pq[u] = g_q; prz[u] = g_rz; pdz[u] = g_dz; pre[u] = g_re;
                        lat = (g_dz || g_re) ? 1 : ((u == 0) ? 14 : 12);
                        busy_e[u] = 1'b1; rz_e[u] = 1'b0; dz_e[u] = 1'b0; re_e[u] = 1'b0;
                        pend[u] = 1'b1;
                        done_at[u] = cyc + lat;
                        free_at[u] = done_at[u] + 2;
                    end
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("busy", 0, {31'd0, b0.busy}, {31'd0, busy_e[0]});
        chk("done", 0, {31'd0, b0.done}, {31'd0, done_e[0]});
        chk("quotient", 0, b0.quotient, q_e[0]);
        chk("rem_zero", 0, {31'd0, b0.rem_zero}, {31'd0, rz_e[0]});
        chk("div_by_zero", 0, {31'd0, b0.div_by_zero}, {31'd0, dz_e[0]});
        chk("range_err", 0, {31'd0, b0.range_err}, {31'd0, re_e[0]});
        chk("busy", 1, {31'd0, b1.busy}, {31'd0, busy_e[1]});
        chk("done", 1, {31'd0, b1.done}, {31'd0, done_e[1]});
        chk("quotient", 1, {16'd0, b1.quotient}, q_e[1]);
        chk("rem_zero", 1, {31'd0, b1.rem_zero}, {31'd0, rz_e[1]});
        chk("div_by_zero", 1, {31'd0, b1.div_by_zero}, {31'd0, dz_e[1]});
        chk("range_err", 1, {31'd0, b1.range_err}, {31'd0, re_e[1]});
    end

    task automatic drive(input int u, input logic s, input logic [31:0] n, input logic [31:0] d);
        if (u == 0) begin
            b0.start = s; b0.dividend = n; b0.divisor = d;
        end else begin
            b1.start = s; b1.dividend = n[15:0]; b1.divisor = d[15:0];
        end
    endtask

    // One directed operation with hand-computed expectations.
    task automatic op(input int u, input logic [31:0] n, input logic [31:0] d,
                      input logic [31:0] eq, input logic erz, input logic edz,
                      input logic ere, input int elat);
        int   k;
        logic seen;
        repeat (2) @(negedge clk);
        drive(u, 1'b1, n, d);
        @(negedge clk);
        drive(u, 1'b0, n, d);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 64) begin
            if ((u == 0) ? b0.done : b1.done) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk("latency", u, k, elat);
        chk("lit_quotient", u, (u == 0) ? b0.quotient : {16'd0, b1.quotient}, eq);
        chk("lit_rem_zero", u, {31'd0, (u == 0) ? b0.rem_zero : b1.rem_zero}, {31'd0, erz});
        chk("lit_div_by_zero", u, {31'd0, (u == 0) ? b0.div_by_zero : b1.div_by_zero}, {31'd0, edz});
        chk("lit_range_err", u, {31'd0, (u == 0) ? b0.range_err : b1.range_err}, {31'd0, ere});
        chk("model_quotient", u, q_e[u], eq);
    endtask

    // Random operand stream with the interesting corner values mixed in.
    task automatic rand_stream(input int u, input int ncyc);
        logic [31:0] m, msb, n, d;
        m   = (u == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        msb = (u == 0) ? 32'h8000_0000 : 32'h0000_8000;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            n = ($urandom & m) | msb;
            d = ($urandom & m) | msb;
            case ($urandom_range(0, 15))
                0: d = n;
                1: d = m;
                2: n = msb;
                3: d = 32'd0;
                4: d = d & ~msb;
                5: n = 32'd0;
                6: n = m;
                default: n = n;
            endcase
            drive(u, 1'b1, n, d);
        end
        @(negedge clk);
        drive(u, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("reset_busy", 0, {31'd0, b0.busy}, 32'd0);
        chk("reset_quotient", 0, b0.quotient, 32'd0);
        #2 reset = 1'b1;

        op(0, 32'hC000_0000, 32'h8000_0000, 32'hC000_0000, 1'b1, 1'b0, 1'b0, 14);
        op(0, 32'h8000_0000, 32'hC000_0000, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 14);
        op(0, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1);
        op(0, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
        op(0, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 14);
        op(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 14);
        op(0, 32'hAAAA_AAAB, 32'hAAAA_AAAB, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 14);
        op(0, 32'h4000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
        op(1, 32'h0000_8000, 32'h0000_C000, 32'h0000_5555, 1'b0, 1'b0, 1'b0, 12);
        op(1, 32'h0000_C000, 32'h0000_8000, 32'h0000_C000, 1'b1, 1'b0, 1'b0, 12);

        // start held high for 40 cycles with changing operands
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 32'h8000_0000 | (i * 32'h0123_4567),
                  ((i % 7) == 3) ? 32'd0 : (32'h8000_0000 | (i * 32'h0765_4321)));
        end
        @(negedge clk);
        drive(0, 1'b0, 32'd0, 32'd0);
        repeat (20) @(negedge clk);

        // reset 5 cycles into an operation
        drive(0, 1'b1, 32'hC000_0000, 32'h8000_0000);
        @(negedge clk);
        drive(0, 1'b0, 32'd0, 32'd0);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_quotient", 0, b0.quotient, 32'd0);
        chk("abort_done", 0, {31'd0, b0.done}, 32'd0);
        #2 reset = 1'b1;
        op(0, 32'hE000_0000, 32'hA000_0000, 32'hB333_3333, 1'b0, 1'b0, 1'b0, 14);

        fork
            rand_stream(0, 30000);
            rand_stream(1, 30000);
        join
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
